// File: rtl/usb_endpoint_tx_packetizer_if.sv
// Endpoint-transmit bundle: device byte stream in, packet valid/ready out, halt/stall.
// The packetizer is the slave; device logic plus transactions layer form the master side.
interface usb_endpoint_tx_packetizer_if #(
    parameter int unsigned MAX_PKT = 8
);
    logic                         i_byteValid;
    logic                         o_byteReady;
    logic [7:0]                   i_byteData;
    logic                         i_halt;
    logic                         o_etStall;
    logic                         o_etValid;
    logic                         i_etReady;
    logic [8*MAX_PKT-1:0]         o_etData;
    logic [$clog2(MAX_PKT):0]     o_etData_nBytes;

    modport slave (
        input  i_byteValid, i_byteData, i_halt, i_etReady,
        output o_byteReady, o_etStall, o_etValid, o_etData, o_etData_nBytes
    );

    modport master (
        output i_byteValid, i_byteData, i_halt, i_etReady,
        input  o_byteReady, o_etStall, o_etValid, o_etData, o_etData_nBytes
    );
endinterface

// File: rtl/usb_endpoint_tx_packetizer.sv
// IN endpoint packetizer: gathers bytes into packets of up to MAX_PKT, flushes on idle timeout.
// Define USB_TX_ZLP_EN to terminate a run of full packets with a zero-length packet.
module usb_endpoint_tx_packetizer #(
    parameter int unsigned MAX_PKT      = 8,
    parameter int unsigned FLUSH_CYCLES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    usb_endpoint_tx_packetizer_if.slave   et
);
    localparam int unsigned NBW = $clog2(MAX_PKT) + 1;
    localparam int unsigned CW  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [NBW-1:0] FULL  = NBW'(MAX_PKT);
    localparam logic [CW-1:0]  FLUSH = CW'(FLUSH_CYCLES);
`ifdef USB_TX_ZLP_EN
    localparam bit ZLP_EN = 1'b1;
`else
    localparam bit ZLP_EN = 1'b0;
`endif

    typedef enum logic {FILL, SEND} state_e;

    state_e               state_q, state_d;
    logic [8*MAX_PKT-1:0] data_q, data_d;
    logic [NBW-1:0]       nbytes_q, nbytes_d;
    logic [CW-1:0]        idle_q, idle_d;
    logic                 zlp_q, zlp_d;
    logic                 stall_q, stall_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;
    logic                 byte_acc, pkt_acc;

    always_comb begin
        byte_acc = et.i_byteValid && ready_q;
        pkt_acc  = valid_q && et.i_etReady;
        state_d  = state_q;
        data_d   = data_q;
        nbytes_d = nbytes_q;
        idle_d   = idle_q;
        zlp_d    = zlp_q;
        stall_d  = et.i_halt;

        // valid_q is never high while stalled, so pkt_acc is always honoured
        if (pkt_acc) begin
            state_d  = FILL;
            data_d   = '0;
            nbytes_d = '0;
            idle_d   = '0;
            zlp_d    = ZLP_EN && (nbytes_q == FULL);
        end else if (!stall_q) begin
            if (state_q == FILL) begin
                if (byte_acc) begin
                    for (int unsigned k = 0; k < MAX_PKT; k++) begin
                        if (nbytes_q == NBW'(k)) data_d[8*k +: 8] = et.i_byteData;
                    end
                    nbytes_d = nbytes_q + NBW'(1);
                    idle_d   = '0;
                    zlp_d    = 1'b0;
                    if (nbytes_q == FULL - NBW'(1)) state_d = SEND;
                end else begin
                    if (idle_q != FLUSH) idle_d = idle_q + CW'(1);
                    if (idle_d == FLUSH && (nbytes_q != '0 || zlp_q)) state_d = SEND;
                end
            end else begin
                idle_d = '0;
            end
        end

        valid_d = (state_d == SEND) && !et.i_halt;
        // Requiring FILL in both the current and next state yields the dead cycle after pktAcc
        ready_d = (state_q == FILL) && (state_d == FILL) && (nbytes_d != FULL) && !et.i_halt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= FILL;
            data_q   <= '0;
            nbytes_q <= '0;
            idle_q   <= '0;
            zlp_q    <= 1'b0;
            stall_q  <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            nbytes_q <= nbytes_d;
            idle_q   <= idle_d;
            zlp_q    <= zlp_d;
            stall_q  <= stall_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign et.o_byteReady     = ready_q;
    assign et.o_etStall       = stall_q;
    assign et.o_etValid       = valid_q;
    assign et.o_etData        = data_q;
    assign et.o_etData_nBytes = nbytes_q;
endmodule
